tl_interval_timer: RTL
======================

Name: tl_interval_timer

Overview:
- Interval timer that serves the highway/farm traffic-light controller.
- The light FSM pulses `st` on every state change. This block restarts and reports `ts` (short interval expired) and `tl` (long interval expired).
- Both durations are programmable in prescaled ticks through a small config write port. New values take effect only at the next `st`.
- Sits between the light FSM and the system clock/config bus.

Parameters:
PRESC_DIV, 50000, clk cycles per timer tick (>=2)
PRESC_W, 16, prescaler width; must hold PRESC_DIV-1
CNT_W, 8, width of elapsed counter and duration registers
TL_DEFAULT, 25, long duration in ticks after reset
TS_DEFAULT, 5, short duration in ticks after reset

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
st  input  1  start/restart timer, 1-cycle pulse from light FSM
cfg_we  input  1  config write strobe
cfg_sel  input  1  0 = long duration, 1 = short duration
cfg_data  input  CNT_W  duration value in ticks
tl  output  1  long interval expired, sticky until next st
ts  output  1  short interval expired, sticky until next st
busy  output  1  timer armed and counting (state COUNT or SHORT_DONE)
tick  output  1  one-cycle prescaler pulse, for debug/observation

Behaviour:
- One clock; reset is asynchronous and active-low (`reset_n`); all state clears immediately on `reset_n` low, with no clk needed.

Reset values:
- state=IDLE, prescaler=0, elapsed=0.
- long_shadow=long_act=TL_DEFAULT; short_shadow=short_act=TS_DEFAULT.
- Outputs tl=0, ts=0, busy=0, tick=0.

Config write:
- On an edge with cfg_we=1, cfg_data is written to long_shadow (cfg_sel=0) or short_shadow (cfg_sel=1).
- Active durations are unaffected by writes.
- cfg_we and st on the same edge: the write lands in the shadow. The _act registers load the pre-write shadow value, so the new value applies from the following st.

States: IDLE, COUNT, SHORT_DONE, LONG_DONE. Outputs are decoded from registers only:
- ts = (state==SHORT_DONE) or (state==LONG_DONE)
- tl = (state==LONG_DONE)
- busy = (state==COUNT) or (state==SHORT_DONE)

Prescaler:
- Runs only when state is COUNT or SHORT_DONE.
- tick = running and prescaler==PRESC_DIV-1; prescaler wraps to 0 on tick.
- In IDLE and LONG_DONE the prescaler holds 0 and tick=0.

Edge with st=1 (highest priority, any state):
- prescaler<=0, elapsed<=0; long_act<=long_shadow, short_act<=short_shadow.
- State goes to LONG_DONE if long_shadow==0, else SHORT_DONE if short_shadow==0, else COUNT.
- tl/ts are therefore low in the cycle after st unless a duration is 0.

Edge with tick=1 and st=0:
- e = elapsed+1, saturating at 2^CNT_W-1; elapsed<=e.
- If e>=long_act: LONG_DONE.
- Else if e>=short_act: SHORT_DONE.
- Else: no state change.
- short_act>=long_act is legal: the timer jumps straight to LONG_DONE with ts and tl rising on the same edge.

Hold and latency:
- LONG_DONE holds until st or reset.
- IDLE holds until st; st pulses are never lost.
- Latency from st edge to ts = short_act*PRESC_DIV cycles; to tl = long_act*PRESC_DIV cycles.

Reset mid-count: returns to IDLE with default durations; shadow writes are discarded.

Test Plan:
1. PRESC_DIV=4, defaults overridden by writes long=5, short=2, then st at edge 0:
   - tick on edges 4,8,12,…
   - ts rises after edge 8; tl rises after edge 20.
   - busy drops after edge 20; tl/ts stay high 50 cycles with no st.
2. Restart mid-count: same setup, st again at edge 10 (ts already high):
   - ts low after edge 10; ts high again after edge 18; tl after edge 30.
3. Config timing: while counting, write long=3.
   - Current interval still ends at tl = 5 ticks.
   - After next st, tl asserts at 3*PRESC_DIV cycles.
   - Also, cfg_we on the same edge as st: the old value is used.
4. Zero/inverted durations:
   - short=0, long=4: ts high on the cycle after st.
   - short=6, long=2: ts and tl rise together after 2 ticks.
   - long=0: both high immediately after st; no ticks.
5. Reset mid-count: drive reset_n=0 between clock edges at elapsed=3.
   - tl=ts=busy=0 immediately; durations back to 25/5.
   - No ticks until the next st.
6. Saturation with CNT_W=3, long=7, short=7: elapsed stops at 7 and tl asserts once. Integration check with the light FSM: every ST_o pulse restarts the timer and the FSM sequence S0→S1→S2→S3→S0 completes.

Source files
------------

// File: rtl/tl_interval_timer.sv
// Interval timer for the highway/farm traffic-light controller: restarts on st and
// reports short (ts) and long (tl) interval expiry in prescaled ticks.
module tl_interval_timer #(
  parameter int unsigned PRESC_DIV  = 50000,
  parameter int unsigned PRESC_W    = 16,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TL_DEFAULT = 25,
  parameter int unsigned TS_DEFAULT = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             st,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             tl,
  output logic             ts,
  output logic             busy,
  output logic             tick
);

  typedef enum logic [1:0] {StIdle, StCount, StShortDone, StLongDone} state_e;

  localparam logic [PRESC_W-1:0] PrescMax = PRESC_W'(PRESC_DIV - 1);
  localparam logic [CNT_W-1:0]   CntMax   = '1;
  localparam logic [CNT_W-1:0]   TlDef    = CNT_W'(TL_DEFAULT);
  localparam logic [CNT_W-1:0]   TsDef    = CNT_W'(TS_DEFAULT);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   elapsed_q, elapsed_d;
  logic [CNT_W-1:0]   long_sh_q, long_sh_d, short_sh_q, short_sh_d;
  logic [CNT_W-1:0]   long_act_q, long_act_d, short_act_q, short_act_d;
  logic [CNT_W-1:0]   elapsed_inc;
  logic               running;

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    elapsed_d   = elapsed_q;
    long_sh_d   = long_sh_q;
    short_sh_d  = short_sh_q;
    long_act_d  = long_act_q;
    short_act_d = short_act_q;

    running     = (state_q == StCount) || (state_q == StShortDone);
    tick        = running && (presc_q == PrescMax);
    elapsed_inc = (elapsed_q == CntMax) ? elapsed_q : elapsed_q + CNT_W'(1);

    if (running) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    if (cfg_we) begin
      if (cfg_sel) short_sh_d = cfg_data;
      else         long_sh_d  = cfg_data;
    end

    // Active durations take the pre-write shadow, so a same-edge write waits for the next st.
    if (st) begin
      presc_d     = '0;
      elapsed_d   = '0;
      long_act_d  = long_sh_q;
      short_act_d = short_sh_q;
      if (long_sh_q == '0)       state_d = StLongDone;
      else if (short_sh_q == '0) state_d = StShortDone;
      else                       state_d = StCount;
    end else if (tick) begin
      elapsed_d = elapsed_inc;
      if (elapsed_inc >= long_act_q)       state_d = StLongDone;
      else if (elapsed_inc >= short_act_q) state_d = StShortDone;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      elapsed_q   <= '0;
      long_sh_q   <= TlDef;
      short_sh_q  <= TsDef;
      long_act_q  <= TlDef;
      short_act_q <= TsDef;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      elapsed_q   <= elapsed_d;
      long_sh_q   <= long_sh_d;
      short_sh_q  <= short_sh_d;
      long_act_q  <= long_act_d;
      short_act_q <= short_act_d;
    end
  end

  assign ts   = (state_q == StShortDone) || (state_q == StLongDone);
  assign tl   = (state_q == StLongDone);
  assign busy = running;

endmodule
